// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor: d = a - b, one digit per clock, LSD first.
// Optional feature: define BCD_SUB_MAG_EN to turn negative results into sign + magnitude.
module bcd_sub_serial #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  hz100,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   d,
  output logic                  bout,
  output logic                  err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
`ifdef BCD_SUB_MAG_EN
    StDone,
    StFix
`else
    StDone
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    d_q, d_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            borrow_q, borrow_d;
  logic            bout_q, bout_d;
  logic            err_q, err_d;

  logic            bad_in;
  logic            last_digit;
  logic [3:0]      cell_x, cell_y, cell_digit;
  logic [4:0]      cell_t;
  logic            cell_borrow;

  function automatic logic has_nonbcd(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign bad_in     = has_nonbcd(a) | has_nonbcd(b);
  assign last_digit = (idx_q == LastIdx);

  // Shared digit-subtract cell; in FIX it computes 0 - d[idx] to form the magnitude.
  always_comb begin
    cell_x = a_q[{idx_q, 2'b00} +: 4];
    cell_y = b_q[{idx_q, 2'b00} +: 4];
`ifdef BCD_SUB_MAG_EN
    if (state_q == StFix) begin
      cell_x = 4'd0;
      cell_y = d_q[{idx_q, 2'b00} +: 4];
    end
`endif
    cell_t      = {1'b0, cell_x} - {1'b0, cell_y} - {4'b0000, borrow_q};
    cell_borrow = cell_t[4];
    cell_digit  = cell_borrow ? (cell_t[3:0] + 4'd10) : cell_t[3:0];
  end

  // State register
  always_ff @(posedge hz100) begin
    if (!reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = bad_in ? StDone : StRun;
      end
      StRun: begin
        if (last_digit) begin
`ifdef BCD_SUB_MAG_EN
          state_d = cell_borrow ? StFix : StDone;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef BCD_SUB_MAG_EN
      StFix: begin
        if (last_digit) state_d = StDone;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          d_d      = '0;
          idx_d    = '0;
          borrow_d = 1'b0;
          bout_d   = 1'b0;
          err_d    = bad_in;
        end
      end
      StRun: begin
        d_d[{idx_q, 2'b00} +: 4] = cell_digit;
        borrow_d = cell_borrow;
        idx_d    = idx_q + 1'b1;
        if (last_digit) begin
          bout_d   = cell_borrow;
          borrow_d = 1'b0;
          idx_d    = '0;
        end
      end
`ifdef BCD_SUB_MAG_EN
      StFix: begin
        d_d[{idx_q, 2'b00} +: 4] = cell_digit;
        borrow_d = cell_borrow;
        idx_d    = idx_q + 1'b1;
        if (last_digit) begin
          borrow_d = 1'b0;
          idx_d    = '0;
        end
      end
`endif
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  assign d    = d_q;
  assign bout = bout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Self-checking bench for bcd_sub_serial: decimal reference model feeding a result scoreboard.
// Define BCD_SUB_MAG_EN here as for the RTL to check the sign/magnitude build.
module tb_bcd_sub_serial;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         hz100 = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, bout, err;
  logic [W-1:0] d;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];

  bcd_sub_serial #(.DIGITS(DIGITS)) dut (
    .hz100 (hz100),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .err   (err)
  );

  always #5 hz100 = ~hz100;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit nonbcd(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t e;
    int   diff;
    int   full = 1;
    for (int i = 0; i < DIGITS; i++) full = full * 10;
    if (nonbcd(aa) || nonbcd(bb)) begin
      e.d = '0; e.bout = 1'b0; e.err = 1'b1; e.lat = 0;
    end else begin
      diff  = bcd_to_int(aa) - bcd_to_int(bb);
      e.err = 1'b0;
      e.lat = DIGITS;
      if (diff < 0) begin
        e.bout = 1'b1;
`ifdef BCD_SUB_MAG_EN
        e.d   = int_to_bcd(-diff);
        e.lat = 2 * DIGITS;
`else
        e.d   = int_to_bcd(full + diff);
`endif
      end else begin
        e.bout = 1'b0;
        e.d    = int_to_bcd(diff);
      end
    end
    return e;
  endfunction

  // One operation; poke re-pulses start and scrambles a/b while the unit is busy.
  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input bit poke);
    exp_t e;
    int   lat;
    sb.push_back(model(aa, bb));
    @(negedge hz100);
    a = aa; b = bb; start = 1'b1;
    @(negedge hz100);
    start = 1'b0;
    if (poke) begin a = 16'h0001; b = 16'h9990; end
    lat = 0;
    while (!done && lat < 100) begin
      check_eq("busy_run", busy, 1);
      start = (poke && lat == 1);
      @(negedge hz100);
      lat++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check_eq("done_seen", done, 1);
    check_eq("busy_done", busy, 1);
    check_eq("latency", lat, e.lat);
    check_eq("d", d, e.d);
    check_eq("bout", bout, e.bout);
    check_eq("err", err, e.err);
    @(negedge hz100);
    check_eq("done_pulse", done, 0);
    check_eq("busy_idle", busy, 0);
    @(negedge hz100);
    check_eq("no_requeue", busy, 0);
    check_eq("d_hold", d, e.d);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge hz100);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_d", d, 0);
    check_eq("rst_bout", bout, 0);
    check_eq("rst_err", err, 0);
    reset = 1'b1;

    run_op(16'h1234, 16'h0234, 1'b0);
    run_op(16'h5000, 16'h0001, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0);
    run_op(16'h12A4, 16'h0000, 1'b0);
    run_op(16'h9999, 16'h9999, 1'b1);
    run_op(16'h0000, 16'h00F0, 1'b0);
    run_op(16'h0100, 16'h0999, 1'b0);

    // Reset during the second RUN cycle abandons the operation.
    @(negedge hz100);
    a = 16'h8765; b = 16'h1234; start = 1'b1;
    @(negedge hz100);
    start = 1'b0;
    @(negedge hz100);
    reset = 1'b0;
    @(negedge hz100);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_d", d, 0);
    check_eq("midrst_bout", bout, 0);
    reset = 1'b1;
    repeat (DIGITS + 2) begin
      @(negedge hz100);
      check_eq("midrst_nodone", done, 0);
    end
    run_op(16'h8765, 16'h1234, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_op(int_to_bcd(int'($urandom_range(0, 9999))),
             int_to_bcd(int'($urandom_range(0, 9999))), 1'b0);
    end

    check_eq("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
